// File: rtl/bus_periph_pkg.sv
// Shared constants for the MemBus peripheral responder: address map, TCON bit
// positions and display reset patterns.
package bus_periph_pkg;

  localparam logic [31:0] ADDR_TH   = 32'h4000_0000;
  localparam logic [31:0] ADDR_TL   = 32'h4000_0004;
  localparam logic [31:0] ADDR_TCON = 32'h4000_0008;
  localparam logic [31:0] ADDR_DIGI = 32'h4000_0010;

  localparam int unsigned TCON_EN = 0;
  localparam int unsigned TCON_IE = 1;
  localparam int unsigned TCON_IF = 2;

  localparam logic [3:0] AN_RESET  = 4'b1110;
  localparam logic [6:0] SEG_RESET = 7'b1000000;

endpackage

// File: rtl/seg7_decoder.sv
// Combinational hex nibble to active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
module seg7_decoder (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'b1111111;
    unique case (hex)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
  end

endmodule

// File: rtl/bus_peripheral.sv
// MemBus target: reload timer (TH/TL/TCON) and 4-digit 7-segment scanner (DIGI).
// Define BUS_PERIPHERAL_PRESCALER_EN to tick the timer every PRESCALE cycles.
module bus_peripheral
  import bus_periph_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned PRESCALE = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] MemBus_Address,
  input  logic [31:0] MemBus_Write_Data,
  output logic [31:0] Device_Read_Data,
  output logic        irq,
  output logic [3:0]  an,
  output logic [6:0]  seg
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam logic [ScanW-1:0] ScanLast = ScanW'(SCAN_DIV - 1);

  logic [31:0] th_q, th_d, tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic [15:0] digi_q, digi_d;
  logic [ScanW-1:0] scan_q, scan_d;
  logic [1:0]  idx_q, idx_d;
  logic        wr_th, wr_tl, wr_tcon, wr_digi, tick;

  assign wr_th   = MemWrite && (MemBus_Address == ADDR_TH);
  assign wr_tl   = MemWrite && (MemBus_Address == ADDR_TL);
  assign wr_tcon = MemWrite && (MemBus_Address == ADDR_TCON);
  assign wr_digi = MemWrite && (MemBus_Address == ADDR_DIGI);

`ifdef BUS_PERIPHERAL_PRESCALER_EN
  localparam int unsigned PreW = $clog2(PRESCALE);
  localparam logic [PreW-1:0] PreLast = PreW'(PRESCALE - 1);

  logic [PreW-1:0] pre_q, pre_d;

  assign tick = tcon_q[TCON_EN] && (pre_q == '0);

  always_comb begin
    pre_d = pre_q;
    if (wr_tcon) begin
      pre_d = PreLast;
    end else if (tcon_q[TCON_EN]) begin
      pre_d = (pre_q == '0) ? PreLast : pre_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) pre_q <= PreLast;
    else       pre_q <= pre_d;
  end
`else
  assign tick = tcon_q[TCON_EN];
`endif

  // Bus writes are applied after the tick update so they override it.
  always_comb begin
    th_d   = wr_th ? MemBus_Write_Data : th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    digi_d = wr_digi ? MemBus_Write_Data[15:0] : digi_q;
    if (tick) begin
      if (tl_q != 32'hFFFF_FFFF) begin
        tl_d = tl_q + 32'd1;
      end else begin
        tl_d = th_q;
        if (tcon_q[TCON_IE]) tcon_d[TCON_IF] = 1'b1;
      end
    end
    if (wr_tl)   tl_d   = MemBus_Write_Data;
    if (wr_tcon) tcon_d = MemBus_Write_Data[2:0];
  end

  always_comb begin
    scan_d = (scan_q == '0) ? ScanLast : scan_q - 1'b1;
    idx_d  = (scan_q == '0) ? idx_q + 2'd1 : idx_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
      digi_q <= '0;
      scan_q <= ScanLast;
      idx_q  <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
      digi_q <= digi_d;
      scan_q <= scan_d;
      idx_q  <= idx_d;
    end
  end

  assign Device_Read_Data = (MemRead && (MemBus_Address == ADDR_TL)) ? tl_q : 32'd0;
  assign irq = tcon_q[TCON_IF];
  assign an  = ~(4'b0001 << idx_q);

  seg7_decoder u_seg7_decoder (
    .hex (digi_q[{idx_q, 2'b00} +: 4]),
    .seg (seg)
  );

endmodule

// File: doc/bus_peripheral.md
# bus_peripheral

Memory-mapped peripheral responder for the single-cycle CPU's MemBus, the target side of the bus the CPU drives. It decodes `MemBus_Address`, holds a 32-bit reload timer and a 4-digit 7-segment display register, and returns read data to the CPU in the same cycle. It sits beside `DataMemory`, and its `Device_Read_Data` feeds the CPU's read mux. Address map:

- TH at 0x40000000, write-only.
- TL at 0x40000004, read/write.
- TCON at 0x40000008, write-only.
- DIGI at 0x40000010, write-only.

## Interface
Parameters:
- `SCAN_DIV`, default 50000: clk cycles each display digit stays active (≥2).
- `PRESCALE`, default 100: clk cycles per timer tick. Used only when `BUS_PERIPHERAL_PRESCALER_EN` is defined (≥2).

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `reset` in 1: synchronous, active-high.
- `MemRead` in 1: CPU read strobe.
- `MemWrite` in 1: CPU write strobe.
- `MemBus_Address` in 32: byte address, full 32-bit compare.
- `MemBus_Write_Data` in 32: write data.
- `Device_Read_Data` out 32: TL when `MemRead` is high and the address is 0x40000004, else 0. Combinational.
- `irq` out 1: equals TCON[2].
- `an` out 4: digit anodes, one-hot active-low.
- `seg` out 7: segments {g,f,e,d,c,b,a}, active-low.

## Operation
- **Writes.** A write is accepted at the posedge when `MemWrite` is high and the address matches exactly. Unmapped addresses are ignored.
  - TH takes [31:0].
  - TL takes [31:0].
  - TCON takes [2:0]. Bit 0 is timer enable, bit 1 is irq enable, bit 2 is irq status.
  - DIGI takes [15:0]: four hex nibbles; nibble 0 is the rightmost digit.
- **Timer.** When TCON[0]=1 on a tick:
  - If TL≠32'hFFFFFFFF: TL←TL+1.
  - If TL=32'hFFFFFFFF: TL←TH, and if TCON[1]=1, set TCON[2]. TCON[2] stays set until software writes TCON.
- **Ticks.** Without the prescaler, every clk cycle is a tick.
- **Collisions.** A CPU write to TL or TCON in the same cycle as a tick wins: the count or the status set is dropped that cycle. A write to TH during an overflow cycle does not affect that reload; the old TH is loaded.
- **Display scanner.** A down-counter runs from SCAN_DIV-1 to 0. At 0 the digit index (2-bit, wraps 3→0) advances.
  - `an` = ~(4'b0001 << index).
  - `seg` = hex decode of the selected nibble. Standard 0–F patterns; 0 → 7'b1000000, 8 → 7'b0000000.
- **Reset values.**
  - TH, TL, TCON, DIGI: 0.
  - Scan counter: SCAN_DIV-1; index: 0.
  - `an`=4'b1110, `seg`=7'b1000000, `irq`=0.
  - `Device_Read_Data`=0 while `MemRead` is low.

## Timing
- Read latency is 0 cycles, as the single-cycle CPU requires. `Device_Read_Data` is a combinational function of `MemRead`, the address and current TL.
- Write latency is 1 edge: the new value is visible on the cycle after the write strobe.
- The overflow reload and the irq set happen on the same edge. `irq` rises 1 cycle after the tick where TL=FFFFFFFF.
- Reset asserted mid-count or mid-scan returns all state to reset values at the next posedge, and takes priority over writes.
- The scanner runs independently of the bus. A DIGI write changes `seg` at the next edge without resetting the scan phase.

## Configuration
- `BUS_PERIPHERAL_PRESCALER_EN` defined:
  - A prescale counter runs PRESCALE-1 down to 0 and generates a tick at 0.
  - The counter runs only while TCON[0]=1. It reloads to PRESCALE-1 on reset and on any TCON write.
- Undefined: no prescale logic; a tick occurs every cycle while TCON[0]=1.

## Structure
- Shared package `bus_periph_pkg`:
  - Address constants `ADDR_TH`, `ADDR_TL`, `ADDR_TCON`, `ADDR_DIGI`.
  - TCON bit indices `TCON_EN`, `TCON_IE`, `TCON_IF`.
  - Reset constants for `an` and `seg`.
- One sub-module: `seg7_decoder`, a combinational 4-bit hex to 7-bit active-low segment decoder, instantiated once on the selected nibble.

## Test plan
- **Reset and basic read:** reset 1 cycle, then read 0x40000004 → `Device_Read_Data`=0, `an`=1110, `seg`=1000000, `irq`=0. With `MemRead`=0 at that address → 0.
- **Count and overflow:** write TH=0xFFFFFFF0, TL=0xFFFFFFFE, TCON=3 (no prescaler) → TL reads FFFFFFFF next cycle, then FFFFFFF0; `irq`=1 from that cycle. Writing TCON=3 clears `irq`.
- **Collision:** with the timer running, write TL=0x100 in a tick cycle → TL=0x100 (not 0x101) next cycle, then 0x101.
- **Unmapped and strobe:** write 0x40000014 and 0x4000000C with data 0xDEAD → no register changes. A write to TH with `MemWrite`=0 → TH unchanged.
- **Display:** SCAN_DIV=4, DIGI=0x1234 → `an` sequence 1110, 1101, 1011, 0111 each for 4 cycles, with `seg` for 4, 3, 2, 1 respectively; then wrap to 1110.
- **Prescaler and reset mid-run** (macro defined, PRESCALE=3): TL increments every 3rd cycle. Asserting reset mid-run → TL=0 and TCON=0 next cycle, and the timer stays stopped.
